// File: rtl/fetch_sequencer_pkg.sv
// Shared types and widths for the fetch sequencer and its performance counters.
package fetch_sequencer_pkg;

  localparam int ADDR_W     = 32;
  localparam int PERF_CNT_W = 16;

  typedef enum logic [2:0] {
    ST_BOOT   = 3'd0,
    ST_RUN    = 3'd1,
    ST_QSTALL = 3'd2,
    ST_IMWAIT = 3'd3,
    ST_HALT   = 3'd4
  } seq_state_e;

  // States in which the fetch stage is live and may capture a redirect.
  function automatic logic is_active(input seq_state_e s);
    return (s == ST_RUN) || (s == ST_QSTALL) || (s == ST_IMWAIT);
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Up-counter that sticks at all-ones; synchronous active-low clear.
module sat_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clk_i,
  input  logic             clr_ni,
  input  logic             inc_i,
  output logic [WIDTH-1:0] count_o
);

  logic [WIDTH-1:0] cnt_q;
  logic [WIDTH-1:0] cnt_d;

  // Next count: increment unless already saturated.
  always_comb begin
    cnt_d = cnt_q;
    if (inc_i && (cnt_q != {WIDTH{1'b1}})) begin
      cnt_d = cnt_q + {{(WIDTH-1){1'b0}}, 1'b1};
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Count register.
  always_ff @(posedge clk_i) begin
    if (!clr_ni) begin
      cnt_q <= {WIDTH{1'b0}};
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign count_o = cnt_q;

endmodule

// File: rtl/fetch_sequencer.sv
// Fetch-stage sequencer: stall/halt control and single-slot pending redirect.
// Optional performance counters are enabled with FETCH_SEQ_PERF_EN.
module fetch_sequencer
  import fetch_sequencer_pkg::*;
(
  input  logic              CLK,
  input  logic              RESET,
  input  logic              start,
  input  logic              halt,
  input  logic              branch_req,
  input  logic [ADDR_W-1:0] branch_target,
  input  logic              im_ready,
  input  logic              tQ_IFID_full,
  output logic              FREEZE,
  output logic              no_new_fetch,
  output logic              taken_branch1,
  output logic [ADDR_W-1:0] nextInstruction_address,
  output logic              fetchNull2,
  output logic [2:0]        seq_state
`ifdef FETCH_SEQ_PERF_EN
  ,
  output logic [PERF_CNT_W-1:0] fetch_cnt,
  output logic [PERF_CNT_W-1:0] stall_cnt,
  output logic [PERF_CNT_W-1:0] redir_cnt
`endif
);

  seq_state_e        state_q, state_d;
  logic              freeze_q, freeze_d;
  logic              pend_q, pend_d;
  logic [ADDR_W-1:0] tgt_q, tgt_d;
  logic              null_q, null_d;
  logic              advance_s;
  logic              capture_s;

  // Halt blocks redirect capture, so a branch arriving with halt is dropped.
  assign capture_s     = branch_req & ~halt & is_active(state_q);
  assign no_new_fetch  = (state_q != ST_RUN) | tQ_IFID_full | ~im_ready;
  assign advance_s     = ~no_new_fetch & ~freeze_q;
  assign taken_branch1 = pend_q & advance_s;
  assign fetchNull2    = null_q & advance_s;
  assign nextInstruction_address = pend_q ? tgt_q : {ADDR_W{1'b0}};
  assign FREEZE        = freeze_q;
  assign seq_state     = state_q;

  // Next-state logic: halt, then queue full, then memory wait.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_BOOT: begin
        if (start) state_d = ST_RUN;
        else       state_d = ST_BOOT;
      end
      ST_HALT: begin
        if (start && !halt) state_d = ST_RUN;
        else                state_d = ST_HALT;
      end
      ST_RUN, ST_QSTALL, ST_IMWAIT: begin
        if (halt)              state_d = ST_HALT;
        else if (tQ_IFID_full) state_d = ST_QSTALL;
        else if (!im_ready)    state_d = ST_IMWAIT;
        else                   state_d = ST_RUN;
      end
      default: state_d = ST_BOOT;
    endcase
    freeze_d = (state_d == ST_BOOT) || (state_d == ST_HALT);
  end

  // Pending redirect (latest wins) and wrong-path null flag.
  always_comb begin
    pend_d = pend_q;
    tgt_d  = tgt_q;
    null_d = null_q;
    if (capture_s) begin
      pend_d = 1'b1;
      tgt_d  = branch_target;
    end else if (taken_branch1) begin
      pend_d = 1'b0;
      tgt_d  = {ADDR_W{1'b0}};
    end else begin
      pend_d = pend_q;
      tgt_d  = tgt_q;
    end
    if (taken_branch1) begin
      null_d = 1'b1;
    end else if (advance_s) begin
      null_d = 1'b0;
    end else begin
      null_d = null_q;
    end
  end

  // State and redirect registers.
  always_ff @(posedge CLK) begin
    if (!RESET) begin
      state_q  <= ST_BOOT;
      freeze_q <= 1'b1;
      pend_q   <= 1'b0;
      tgt_q    <= {ADDR_W{1'b0}};
      null_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      freeze_q <= freeze_d;
      pend_q   <= pend_d;
      tgt_q    <= tgt_d;
      null_q   <= null_d;
    end
  end

`ifdef FETCH_SEQ_PERF_EN
  logic stall_s;
  assign stall_s = (state_q == ST_QSTALL) || (state_q == ST_IMWAIT);

  sat_counter #(.WIDTH(PERF_CNT_W)) u_fetch_cnt (
    .clk_i  (CLK),
    .clr_ni (RESET),
    .inc_i  (advance_s),
    .count_o(fetch_cnt)
  );

  sat_counter #(.WIDTH(PERF_CNT_W)) u_stall_cnt (
    .clk_i  (CLK),
    .clr_ni (RESET),
    .inc_i  (stall_s),
    .count_o(stall_cnt)
  );

  sat_counter #(.WIDTH(PERF_CNT_W)) u_redir_cnt (
    .clk_i  (CLK),
    .clr_ni (RESET),
    .inc_i  (taken_branch1),
    .count_o(redir_cnt)
  );
`endif

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed self-checking bench for fetch_sequencer (counters checked when FETCH_SEQ_PERF_EN is set).
module tb_fetch_sequencer;

  logic        CLK = 1'b0;
  logic        RESET;
  logic        start;
  logic        halt;
  logic        branch_req;
  logic [31:0] branch_target;
  logic        im_ready;
  logic        tQ_IFID_full;
  logic        FREEZE;
  logic        no_new_fetch;
  logic        taken_branch1;
  logic [31:0] nextInstruction_address;
  logic        fetchNull2;
  logic [2:0]  seq_state;
`ifdef FETCH_SEQ_PERF_EN
  logic [15:0] fetch_cnt;
  logic [15:0] stall_cnt;
  logic [15:0] redir_cnt;
`endif

  int checks = 0;
  int errors = 0;

  always #5 CLK = ~CLK;

  fetch_sequencer dut (
    .CLK                    (CLK),
    .RESET                  (RESET),
    .start                  (start),
    .halt                   (halt),
    .branch_req             (branch_req),
    .branch_target          (branch_target),
    .im_ready               (im_ready),
    .tQ_IFID_full           (tQ_IFID_full),
    .FREEZE                 (FREEZE),
    .no_new_fetch           (no_new_fetch),
    .taken_branch1          (taken_branch1),
    .nextInstruction_address(nextInstruction_address),
    .fetchNull2             (fetchNull2),
    .seq_state              (seq_state)
`ifdef FETCH_SEQ_PERF_EN
    ,
    .fetch_cnt              (fetch_cnt),
    .stall_cnt              (stall_cnt),
    .redir_cnt              (redir_cnt)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  initial begin
    RESET = 1'b0; start = 1'b0; halt = 1'b0; branch_req = 1'b1;
    branch_target = 32'h0000_0ABC; im_ready = 1'b1; tQ_IFID_full = 1'b0;
    tick(); tick();
    branch_req = 1'b0;
    #1;
    chk("rst_state",  32'(seq_state), 32'd0);
    chk("rst_freeze", 32'(FREEZE), 32'd1);
    chk("rst_nnf",    32'(no_new_fetch), 32'd1);
    chk("rst_taken",  32'(taken_branch1), 32'd0);
    chk("rst_null",   32'(fetchNull2), 32'd0);
    chk("rst_addr",   nextInstruction_address, 32'h0);

    // start pulse
    RESET = 1'b1; start = 1'b1;
    #1;
    chk("boot_freeze_pre", 32'(FREEZE), 32'd1);
    tick(); start = 1'b0; #1;
    chk("run_state",  32'(seq_state), 32'd1);
    chk("run_freeze", 32'(FREEZE), 32'd0);
    chk("run_nnf",    32'(no_new_fetch), 32'd0);

    // queue full for three cycles
    tQ_IFID_full = 1'b1; #1;
    chk("qf1_nnf",   32'(no_new_fetch), 32'd1);
    chk("qf1_state", 32'(seq_state), 32'd1);
    tick(); #1;
    chk("qf2_nnf",   32'(no_new_fetch), 32'd1);
    chk("qf2_state", 32'(seq_state), 32'd2);
    tick(); #1;
    chk("qf3_nnf",   32'(no_new_fetch), 32'd1);
    chk("qf3_state", 32'(seq_state), 32'd2);
    tick(); tQ_IFID_full = 1'b0; #1;
    chk("qf4_state", 32'(seq_state), 32'd2);
    chk("qf4_nnf",   32'(no_new_fetch), 32'd1);
    tick(); #1;
    chk("qf_back_state", 32'(seq_state), 32'd1);
    chk("qf_back_nnf",   32'(no_new_fetch), 32'd0);

    // branch to 0x400 in RUN
    branch_req = 1'b1; branch_target = 32'h0000_0400; #1;
    chk("br400_taken_early", 32'(taken_branch1), 32'd0);
    tick(); branch_req = 1'b0; #1;
    chk("br400_taken", 32'(taken_branch1), 32'd1);
    chk("br400_addr",  nextInstruction_address, 32'h400);
    chk("br400_null0", 32'(fetchNull2), 32'd0);
    tick(); #1;
    chk("br400_null",  32'(fetchNull2), 32'd1);
    chk("br400_taken_clr", 32'(taken_branch1), 32'd0);
    chk("br400_addr_clr", nextInstruction_address, 32'h0);
    tick(); #1;
    chk("br400_null_clr", 32'(fetchNull2), 32'd0);

    // branch 0x100 then 0x200 during a 4-cycle memory wait
    branch_req = 1'b1; branch_target = 32'h0000_0100; #1;
    tick(); branch_req = 1'b0; im_ready = 1'b0; #1;
    chk("w1_addr",  nextInstruction_address, 32'h100);
    chk("w1_taken", 32'(taken_branch1), 32'd0);
    tick(); branch_req = 1'b1; branch_target = 32'h0000_0200; #1;
    chk("w2_state", 32'(seq_state), 32'd3);
    chk("w2_addr",  nextInstruction_address, 32'h100);
    tick(); branch_req = 1'b0; #1;
    chk("w3_addr",  nextInstruction_address, 32'h200);
    chk("w3_taken", 32'(taken_branch1), 32'd0);
    tick(); #1;
    chk("w4_taken", 32'(taken_branch1), 32'd0);
    tick(); im_ready = 1'b1; #1;
    chk("w5_state", 32'(seq_state), 32'd3);
    chk("w5_taken", 32'(taken_branch1), 32'd0);
    tick(); #1;
    chk("w6_taken", 32'(taken_branch1), 32'd1);
    chk("w6_addr",  nextInstruction_address, 32'h200);
    tick(); #1;
    chk("w7_taken", 32'(taken_branch1), 32'd0);
    chk("w7_null",  32'(fetchNull2), 32'd1);

    // pending redirect survives halt; branch with halt ignored
    branch_req = 1'b1; branch_target = 32'h0000_0500; im_ready = 1'b0; #1;
    tick(); halt = 1'b1; branch_req = 1'b1; branch_target = 32'h0000_0999; #1;
    chk("h0_state", 32'(seq_state), 32'd3);
    chk("h0_addr",  nextInstruction_address, 32'h500);
    tick(); halt = 1'b0; branch_req = 1'b0; im_ready = 1'b1; #1;
    chk("h1_state",  32'(seq_state), 32'd4);
    chk("h1_freeze", 32'(FREEZE), 32'd1);
    chk("h1_addr",   nextInstruction_address, 32'h500);
    chk("h1_taken",  32'(taken_branch1), 32'd0);
    start = 1'b1; halt = 1'b1; branch_req = 1'b1; branch_target = 32'h0000_0777;
    tick(); halt = 1'b0; branch_req = 1'b0; #1;
    chk("h2_state", 32'(seq_state), 32'd4);
    chk("h2_addr",  nextInstruction_address, 32'h500);
    tick(); start = 1'b0; #1;
    chk("h3_state",  32'(seq_state), 32'd1);
    chk("h3_freeze", 32'(FREEZE), 32'd0);
    chk("h3_taken",  32'(taken_branch1), 32'd1);
    chk("h3_addr",   nextInstruction_address, 32'h500);
    tick(); #1;
    chk("h4_null", 32'(fetchNull2), 32'd1);

    // reset mid-redirect discards the target
    branch_req = 1'b1; branch_target = 32'h0000_0600; im_ready = 1'b0;
    tick(); branch_req = 1'b0; #1;
    chk("r0_addr", nextInstruction_address, 32'h600);
    RESET = 1'b0;
    tick(); #1;
    chk("r1_state",  32'(seq_state), 32'd0);
    chk("r1_freeze", 32'(FREEZE), 32'd1);
    chk("r1_addr",   nextInstruction_address, 32'h0);
    chk("r1_nnf",    32'(no_new_fetch), 32'd1);
    RESET = 1'b1; start = 1'b1; im_ready = 1'b1;
    tick(); start = 1'b0; #1;
    chk("r2_state", 32'(seq_state), 32'd1);
    chk("r2_taken", 32'(taken_branch1), 32'd0);
    chk("r2_addr",  nextInstruction_address, 32'h0);

`ifdef FETCH_SEQ_PERF_EN
    RESET = 1'b0;
    tick(); #1;
    chk("p0_fetch", 32'(fetch_cnt), 32'd0);
    chk("p0_stall", 32'(stall_cnt), 32'd0);
    chk("p0_redir", 32'(redir_cnt), 32'd0);
    RESET = 1'b1; start = 1'b1;
    tick(); start = 1'b0; #1;
    repeat (70000) @(posedge CLK);
    #1;
    chk("p1_fetch_sat", 32'(fetch_cnt), 32'h0000_FFFF);
    chk("p1_stall",     32'(stall_cnt), 32'd0);
    RESET = 1'b0;
    tick(); #1;
    chk("p2_fetch", 32'(fetch_cnt), 32'd0);
    chk("p2_stall", 32'(stall_cnt), 32'd0);
    chk("p2_redir", 32'(redir_cnt), 32'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
